// File: rtl/bram_playback_sequencer_if.sv
// AXIS-style sample stream carrying waveform words from the sequencer to the DAC.
interface bram_playback_sequencer_if #(
  parameter int unsigned DATA_W = 512
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/bram_playback_sequencer.sv
// Walks waveform BRAM words from start to stop pointer and streams them out over AXIS,
// one-shot or looped, through a credit-gated FIFO that absorbs read latency and stalls.
module bram_playback_sequencer #(
  parameter int unsigned DATA_W     = 512,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned RD_LATENCY = 2,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      loop_en,
  input  logic [ADDR_W-1:0]         start_ptr,
  input  logic [ADDR_W-1:0]         stop_ptr,
  output logic                      bram_en,
  output logic [ADDR_W-1:0]         bram_addr,
  input  logic [DATA_W-1:0]         bram_dout,
  bram_playback_sequencer_if.master m_axis,
  output logic                      busy,
  output logic                      cfg_err,
  output logic [15:0]               wrap_count
);

  localparam int unsigned STRIDE  = DATA_W / 8;
  localparam int unsigned ALIGN_W = $clog2(STRIDE);
  localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned CRD_W   = $clog2(FIFO_DEPTH + RD_LATENCY + 2);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t state, state_n;

  logic              enable_q;
  logic              loop_q, loop_n;
  logic [ADDR_W-1:0] start_q, start_n;
  logic [ADDR_W-1:0] stop_q, stop_n;
  logic [ADDR_W-1:0] rd_addr, rd_addr_n;
  logic [ADDR_W-1:0] bram_addr_n;
  logic              bram_en_n;
  logic              cfg_err_n;
  logic [15:0]       wrap_n;

  logic [RD_LATENCY-1:0] rd_pipe;
  logic [CRD_W-1:0]      in_flight;
  logic [CRD_W-1:0]      credit_used;

  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  fifo_wr, fifo_rd;
  logic [CNT_W-1:0]  fifo_count;
  logic              push, pop;

  logic start_ok, last_word;

  assign start_ok  = (start_ptr[ALIGN_W-1:0] == '0) && (stop_ptr[ALIGN_W-1:0] == '0)
                     && (stop_ptr > start_ptr);
  assign last_word = (rd_addr == stop_q - ADDR_W'(STRIDE));

  // Reads in flight: the one being presented to the BRAM now plus those still in its pipeline.
  always_comb begin
    in_flight = CRD_W'(bram_en);
    for (int unsigned i = 0; i < RD_LATENCY; i++) begin
      in_flight = in_flight + CRD_W'(rd_pipe[i]);
    end
    credit_used = in_flight + CRD_W'(fifo_count);
  end

  always_comb begin
    state_n     = state;
    start_n     = start_q;
    stop_n      = stop_q;
    loop_n      = loop_q;
    rd_addr_n   = rd_addr;
    bram_en_n   = 1'b0;
    bram_addr_n = bram_addr;
    wrap_n      = wrap_count;
    cfg_err_n   = cfg_err;
    case (state)
      IDLE: begin
        if (enable && !enable_q) begin
          if (start_ok) begin
            start_n   = start_ptr;
            stop_n    = stop_ptr;
            loop_n    = loop_en;
            rd_addr_n = start_ptr;
            cfg_err_n = 1'b0;
            wrap_n    = '0;
            state_n   = RUN;
          end else begin
            cfg_err_n = 1'b1;
          end
        end
      end
      RUN: begin
        if (!enable) begin
          state_n = DRAIN;
        end else if (credit_used < CRD_W'(FIFO_DEPTH)) begin
          bram_en_n   = 1'b1;
          bram_addr_n = rd_addr;
          if (last_word) begin
            if (wrap_count != '1) wrap_n = wrap_count + 16'd1;
            if (loop_q) rd_addr_n = start_q;
            else        state_n   = DRAIN;
          end else begin
            rd_addr_n = rd_addr + ADDR_W'(STRIDE);
          end
        end
      end
      DRAIN: begin
        if (in_flight == '0 && fifo_count == '0) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      enable_q   <= 1'b0;
      start_q    <= '0;
      stop_q     <= '0;
      loop_q     <= 1'b0;
      rd_addr    <= '0;
      bram_en    <= 1'b0;
      bram_addr  <= '0;
      wrap_count <= '0;
      cfg_err    <= 1'b0;
    end else begin
      state      <= state_n;
      enable_q   <= enable;
      start_q    <= start_n;
      stop_q     <= stop_n;
      loop_q     <= loop_n;
      rd_addr    <= rd_addr_n;
      bram_en    <= bram_en_n;
      bram_addr  <= bram_addr_n;
      wrap_count <= wrap_n;
      cfg_err    <= cfg_err_n;
    end
  end

  // rd_pipe[RD_LATENCY-1] marks the cycle in which the matching bram_dout is valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pipe <= '0;
    end else begin
      rd_pipe[0] <= bram_en;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        rd_pipe[i] <= rd_pipe[i-1];
      end
    end
  end

  assign push = rd_pipe[RD_LATENCY-1];
  assign pop  = m_axis.tvalid && m_axis.tready;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[fifo_wr] <= bram_dout;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_wr    <= '0;
      fifo_rd    <= '0;
      fifo_count <= '0;
    end else begin
      if (push) fifo_wr <= (fifo_wr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : fifo_wr + PTR_W'(1);
      if (pop)  fifo_rd <= (fifo_rd == PTR_W'(FIFO_DEPTH - 1)) ? '0 : fifo_rd + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign m_axis.tvalid = (fifo_count != '0);
  assign m_axis.tdata  = m_axis.tvalid ? fifo_mem[fifo_rd] : '0;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_bram_playback_sequencer.sv
// Bench for bram_playback_sequencer: BRAM latency model, AXIS monitor with scoreboard,
// table of start/stop configurations plus looping and mid-run reset sequences.
module tb_bram_playback_sequencer;

  localparam int unsigned DATA_W     = 512;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned RD_LATENCY = 2;
  localparam int unsigned FIFO_DEPTH = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic              loop_en;
  logic [ADDR_W-1:0] start_ptr;
  logic [ADDR_W-1:0] stop_ptr;
  logic              bram_en;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_dout;
  logic              busy;
  logic              cfg_err;
  logic [15:0]       wrap_count;

  bram_playback_sequencer_if #(.DATA_W(DATA_W)) axis ();

  bram_playback_sequencer #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .RD_LATENCY(RD_LATENCY),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .loop_en   (loop_en),
    .start_ptr (start_ptr),
    .stop_ptr  (stop_ptr),
    .bram_en   (bram_en),
    .bram_addr (bram_addr),
    .bram_dout (bram_dout),
    .m_axis    (axis),
    .busy      (busy),
    .cfg_err   (cfg_err),
    .wrap_count(wrap_count)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] word_of(input logic [31:0] a);
    return {8{~a, a}};
  endfunction

  // BRAM: data for the address presented with bram_en appears RD_LATENCY cycles later.
  logic [DATA_W-1:0] bram_pipe [RD_LATENCY];
  always @(posedge clk) begin
    bram_pipe[0] <= bram_en ? word_of(bram_addr) : '0;
    for (int i = 1; i < RD_LATENCY; i++) bram_pipe[i] <= bram_pipe[i-1];
  end
  assign bram_dout = bram_pipe[RD_LATENCY-1];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard and monitor state
  logic [DATA_W-1:0] exp_q [$];
  int   beats = 0, n_reads = 0, gaps = 0;
  int   last_beat_cyc = -1, first_tv_cyc = -1;
  bit   bp_mode = 1'b0, fixed_ready = 1'b0, prev_stall = 1'b0, rst_edge = 1'b0;
  logic [DATA_W-1:0] stall_data;

  always @(posedge clk) rst_edge <= rst;

  always @(negedge clk) begin
    if (bram_en) n_reads++;
    if (axis.tvalid && first_tv_cyc < 0) first_tv_cyc = cyc;
    if (prev_stall && !rst_edge) begin
      chk("stall_valid", axis.tvalid, 1);
      chk("stall_data", axis.tdata, stall_data);
    end
    if (busy) chk("fifo_bound", dut.fifo_count <= FIFO_DEPTH, 1);
    axis.tready = bp_mode ? ($urandom_range(0, 99) < 30) : fixed_ready;
    prev_stall  = axis.tvalid && !axis.tready;
    stall_data  = axis.tdata;
    if (axis.tvalid && axis.tready) begin
      beats++;
      if (last_beat_cyc >= 0 && cyc != last_beat_cyc + 1) gaps++;
      last_beat_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_beat: got %0h expected no beat", axis.tdata);
      end else begin
        chk("beat_data", axis.tdata, exp_q.pop_front());
      end
    end
  end

  task automatic clear_stats();
    beats = 0; gaps = 0; last_beat_cyc = -1; first_tv_cyc = -1;
  endtask

  task automatic wait_idle(input int lim, input string nm);
    int k = 0;
    while (busy && k < lim) begin
      step();
      k++;
    end
    if (busy) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: busy=1 after %0d cycles, required 0", nm, lim);
    end
  endtask

  task automatic wait_beats(input int want, input int lim, input string nm);
    int k = 0;
    while (beats < want && k < lim) begin
      step();
      k++;
    end
    if (beats < want) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: beats=%0d, required %0d", nm, beats, want);
    end
  endtask

  // Returns the cycle index of the enable rising edge (edge N).
  task automatic rise_enable(output int n_cyc);
    enable = 1'b0;
    step();
    enable = 1'b1;
    step();
    n_cyc = cyc;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_bram_en"}, bram_en, 0);
    chk({tag, "_bram_addr"}, bram_addr, 0);
    chk({tag, "_tvalid"}, axis.tvalid, 0);
    chk({tag, "_tdata"}, axis.tdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_cfg_err"}, cfg_err, 0);
    chk({tag, "_wrap"}, wrap_count, 0);
  endtask

  typedef struct {
    logic [31:0] start;
    logic [31:0] stop;
    bit          loop;
    bit          bp;
    bit          exp_err;
    int          exp_beats;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int n_cyc, r0, nr;

    tbl[0] = '{32'h000, 32'hC00, 1'b0, 1'b0, 1'b0, 48};
    tbl[1] = '{32'h000, 32'hC00, 1'b0, 1'b1, 1'b0, 48};
    tbl[2] = '{32'h080, 32'h080, 1'b0, 1'b0, 1'b1, 0};
    tbl[3] = '{32'h020, 32'h100, 1'b0, 1'b0, 1'b1, 0};
    tbl[4] = '{32'h040, 32'h080, 1'b0, 1'b0, 1'b0, 1};
    tbl[5] = '{32'h100, 32'h040, 1'b0, 1'b0, 1'b1, 0};
    tbl[6] = '{32'h3C0, 32'h440, 1'b0, 1'b1, 1'b0, 2};

    rst = 1'b1; enable = 1'b0; loop_en = 1'b0; start_ptr = '0; stop_ptr = '0;
    step(); step(); step();
    chk_reset_outputs("reset");
    rst = 1'b0;
    step();

    for (int i = 0; i < 7; i++) begin
      bp_mode = tbl[i].bp; fixed_ready = 1'b1;
      loop_en = tbl[i].loop; start_ptr = tbl[i].start; stop_ptr = tbl[i].stop;
      if (!tbl[i].exp_err)
        for (logic [31:0] a = tbl[i].start; a < tbl[i].stop; a += 32'd64) exp_q.push_back(word_of(a));
      clear_stats();
      r0 = n_reads;
      rise_enable(n_cyc);
      if (tbl[i].exp_err) repeat (6) step();
      else wait_idle(3000, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_cfg_err", i), cfg_err, tbl[i].exp_err);
      chk($sformatf("vec%0d_busy", i), busy, 0);
      chk($sformatf("vec%0d_beats", i), beats, tbl[i].exp_beats);
      chk($sformatf("vec%0d_reads", i), n_reads - r0, tbl[i].exp_beats);
      chk($sformatf("vec%0d_leftover", i), exp_q.size(), 0);
      if (!tbl[i].exp_err) begin
        chk($sformatf("vec%0d_wrap", i), wrap_count, 1);
        chk($sformatf("vec%0d_latency", i), first_tv_cyc - n_cyc, 2 + RD_LATENCY);
        if (!tbl[i].bp) chk($sformatf("vec%0d_gaps", i), gaps, 0);
      end
      exp_q.delete();
      enable = 1'b0;
      step();
    end

    // Looping over three words, stopped by enable going low.
    bp_mode = 1'b0; fixed_ready = 1'b1;
    loop_en = 1'b1; start_ptr = 32'h40; stop_ptr = 32'h100;
    for (int i = 0; i < 300; i++) exp_q.push_back(word_of(32'h40 + 32'(i % 3) * 32'd64));
    clear_stats();
    r0 = n_reads;
    rise_enable(n_cyc);
    wait_beats(20, 500, "loop");
    enable = 1'b0;
    wait_idle(500, "loop");
    nr = n_reads - r0;
    chk("loop_beats_eq_reads", beats, nr);
    chk("loop_min_beats", beats >= 20, 1);
    chk("loop_wrap", wrap_count, 16'(nr / 3));
    chk("loop_gaps", gaps, 0);
    chk("loop_consumed", exp_q.size(), 300 - beats);
    exp_q.delete();
    step();

    // Single-word region repeats the same address while looping.
    loop_en = 1'b1; start_ptr = 32'h80; stop_ptr = 32'hC0;
    for (int i = 0; i < 100; i++) exp_q.push_back(word_of(32'h80));
    clear_stats();
    r0 = n_reads;
    rise_enable(n_cyc);
    wait_beats(10, 300, "single");
    enable = 1'b0;
    wait_idle(300, "single");
    nr = n_reads - r0;
    chk("single_beats_eq_reads", beats, nr);
    chk("single_wrap", wrap_count, 16'(nr));
    chk("single_gaps", gaps, 0);
    exp_q.delete();
    step();

    // Reset mid-run with the FIFO full and the sink stalled.
    fixed_ready = 1'b0;
    loop_en = 1'b0; start_ptr = 32'h0; stop_ptr = 32'hC00;
    clear_stats();
    r0 = n_reads;
    rise_enable(n_cyc);
    repeat (20) step();
    chk("full_reads", n_reads - r0, FIFO_DEPTH);
    chk("full_count", dut.fifo_count, FIFO_DEPTH);
    chk("full_tvalid", axis.tvalid, 1);
    chk("full_busy", busy, 1);
    rst = 1'b1; enable = 1'b0;
    step();
    chk_reset_outputs("midrst");
    rst = 1'b0;
    step();

    fixed_ready = 1'b1;
    for (logic [31:0] a = 32'h0; a < 32'hC00; a += 32'd64) exp_q.push_back(word_of(a));
    clear_stats();
    r0 = n_reads;
    rise_enable(n_cyc);
    wait_idle(3000, "replay");
    chk("replay_beats", beats, 48);
    chk("replay_leftover", exp_q.size(), 0);
    chk("replay_wrap", wrap_count, 1);
    chk("replay_latency", first_tv_cyc - n_cyc, 2 + RD_LATENCY);
    chk("replay_gaps", gaps, 0);
    exp_q.delete();
    enable = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
